// File: rtl/pc_ras_unit.sv
// Program counter with branch/jump/jump-register redirect and a small
// circular return-address stack used to predict and check returns.
module pc_ras_unit #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        pcenable,
  input  logic [1:0]                  pcsrc,
  input  logic                        BEQ,
  input  logic                        zero_f,
  input  logic [15:0]                 immed,
  input  logic [25:0]                 jaddr,
  input  logic [PC_W-1:0]             rdat1,
  input  logic                        link,
  input  logic                        ret,
  output logic [PC_W-1:0]             pcout,
  output logic [PC_W-1:0]             pcplus4,
  output logic [PC_W-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_empty,
  output logic                        ras_full,
  output logic                        ras_miss
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_J   = 2'b10;
  localparam logic [1:0] SRC_JR  = 2'b11;

  logic [PC_W-1:0]  stack [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;

  logic [PC_W-1:0]  br_off;
  logic [PC_W-1:0]  br_tgt;
  logic [PC_W-1:0]  j_tgt;
  logic [PC_W-1:0]  jr_tgt;
  logic             taken;

  logic [PC_W-1:0]  pc_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             miss_nxt;
  logic             push;

  // Low bits of the register target are dropped by the alignment.
  logic unused_rdat1_lsbs;
  assign unused_rdat1_lsbs = ^rdat1[1:0];

  // Target arithmetic and stack status.
  always_comb begin
    pcplus4   = pcout + PC_W'(4);
    br_off    = {{(PC_W-18){immed[15]}}, immed, 2'b00};
    br_tgt    = pcplus4 + br_off;
    j_tgt     = {pcplus4[PC_W-1:28], jaddr, 2'b00};
    jr_tgt    = {rdat1[PC_W-1:2], 2'b00};
    taken     = (BEQ == zero_f);
    top_idx   = ptr - PTR_W'(1);
    ras_empty = (ras_count == CNT_W'(0));
    ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    ras_top   = ras_empty ? '0 : stack[top_idx];
  end

  // Next PC and stack pointer/count; the stack only predicts, never redirects.
  always_comb begin
    pc_nxt   = pcout;
    ptr_nxt  = ptr;
    cnt_nxt  = ras_count;
    miss_nxt = 1'b0;
    push     = 1'b0;
    if (pcenable) begin
      case (pcsrc)
        SRC_SEQ: pc_nxt = pcplus4;
        SRC_BR:  pc_nxt = taken ? br_tgt : pcplus4;
        SRC_J: begin
          pc_nxt = j_tgt;
          if (link) begin
            push    = 1'b1;
            ptr_nxt = ptr + PTR_W'(1);
            if (!ras_full) cnt_nxt = ras_count + CNT_W'(1);
          end
        end
        SRC_JR: begin
          pc_nxt = jr_tgt;
          if (ret) begin
            if (ras_empty) begin
              miss_nxt = 1'b1;
            end else begin
              ptr_nxt  = top_idx;
              cnt_nxt  = ras_count - CNT_W'(1);
              miss_nxt = (ras_top != jr_tgt);
            end
          end
        end
        default: pc_nxt = pcplus4;
      endcase
    end
  end

  // PC, pointer, count and miss pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pcout     <= RESET_PC;
      ptr       <= '0;
      ras_count <= '0;
      ras_miss  <= 1'b0;
    end else begin
      pcout     <= pc_nxt;
      ptr       <= ptr_nxt;
      ras_count <= cnt_nxt;
      ras_miss  <= miss_nxt;
    end
  end

  // Stack entries; contents survive reset since the count gates visibility.
  always_ff @(posedge CLK) begin
    if (!RST && push) stack[ptr] <= pcplus4;
  end

endmodule
